// File: rtl/speck_digest_collector_if.sv
// rtl/speck_digest_collector_if.sv - nibble stream and digest handshake bundle for speck_digest_collector
//
// Purpose: groups the collector's nibble input, its expected-tag input and the
// digest valid/ready output side so that one port connects them.
// Signals:
//   clear         producer -> collector  sync abort of the partial digest and flags
//   nib_in        producer -> collector  hash nibble from the datapath
//   nib_valid     producer -> collector  nib_in valid this cycle (no backpressure)
//   exp_tag       producer -> collector  expected digest, sampled on completion
//   digest_ready  consumer -> collector  consumer takes the digest when valid&ready
//   digest_out    collector -> consumer  assembled digest
//   digest_valid  collector -> consumer  digest_out complete and held
//   tag_match     collector -> consumer  digest_out matched exp_tag at completion
//   nib_count     collector -> consumer  nibbles in the current partial digest
//   overflow      collector -> consumer  sticky: nibble dropped while holding
// Modports: master = environment (producer + consumer), slave = collector.
interface speck_digest_collector_if #(
  parameter int NIB_W    = 4,
  parameter int DIGEST_W = 64,
  parameter int CNT_W    = $clog2(DIGEST_W / NIB_W) + 1
);
  logic                clear;
  logic [NIB_W-1:0]    nib_in;
  logic                nib_valid;
  logic [DIGEST_W-1:0] exp_tag;
  logic [DIGEST_W-1:0] digest_out;
  logic                digest_valid;
  logic                digest_ready;
  logic                tag_match;
  logic [CNT_W-1:0]    nib_count;
  logic                overflow;

  modport master (
    output clear, nib_in, nib_valid, exp_tag, digest_ready,
    input  digest_out, digest_valid, tag_match, nib_count, overflow
  );

  modport slave (
    input  clear, nib_in, nib_valid, exp_tag, digest_ready,
    output digest_out, digest_valid, tag_match, nib_count, overflow
  );
endinterface

// File: rtl/speck_digest_collector.sv
// rtl/speck_digest_collector.sv - packs the hash nibble stream into a digest and hands it off
//
// Purpose: collects DIGEST_W/NIB_W nibbles MSB-first into a digest word, holds it
// on a valid/ready handshake, flags whether it equals the expected tag and flags
// nibbles lost while a finished digest is waiting.
// Ports:
//   clk      in  system clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      slave modport of speck_digest_collector_if (stream in, digest out)
module speck_digest_collector #(
  parameter int NIB_W    = 4,
  parameter int DIGEST_W = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  speck_digest_collector_if.slave bus
);
  localparam int NIBS  = DIGEST_W / NIB_W;
  localparam int CNT_W = $clog2(NIBS) + 1;
  localparam int SRG_W = DIGEST_W - NIB_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NIBS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

  state_t              state_q, state_d;
  // Only the lower nibbles are kept: the oldest nibble leaves the register
  // exactly when the word becomes complete and is copied into digest_q.
  logic [SRG_W-1:0]    sreg_q, sreg_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic                tag_q, tag_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [DIGEST_W-1:0] shifted;

  assign shifted = {sreg_q, bus.nib_in};

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      sreg_q   <= '0;
      digest_q <= '0;
      tag_q    <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      digest_q <= digest_d;
      tag_q    <= tag_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    digest_d = digest_q;
    tag_d    = tag_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (bus.clear) begin
      // digest_out deliberately survives a clear
      state_d = S_IDLE;
      count_d = '0;
      tag_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.nib_valid) begin
            sreg_d  = shifted[SRG_W-1:0];
            count_d = CNT_ONE;
            state_d = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (bus.nib_valid) begin
            sreg_d = shifted[SRG_W-1:0];
            if (count_q == CNT_LAST) begin
              state_d  = S_HOLD;
              count_d  = CNT_FULL;
              digest_d = shifted;
              tag_d    = (shifted == bus.exp_tag);
            end else begin
              count_d = count_q + CNT_ONE;
            end
          end
        end
        S_HOLD: begin
          if (bus.digest_ready) begin
            // A nibble arriving on the accept cycle starts the next digest
            if (bus.nib_valid) begin
              sreg_d  = shifted[SRG_W-1:0];
              count_d = CNT_ONE;
              state_d = S_COLLECT;
            end else begin
              count_d = '0;
              state_d = S_IDLE;
            end
          end else if (bus.nib_valid) begin
            ovf_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.digest_valid = (state_q == S_HOLD);
    bus.digest_out   = digest_q;
    bus.tag_match    = tag_q;
    bus.nib_count    = count_q;
    bus.overflow     = ovf_q;
  end
endmodule

// File: tb/tb_speck_digest_collector.sv
// tb/tb_speck_digest_collector.sv - self-checking bench for speck_digest_collector
module tb_speck_digest_collector;
  logic clk = 1'b0;
  logic reset_n;

  speck_digest_collector_if bus ();

  speck_digest_collector dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [63:0] tag;
    logic        match;
  } vec_t;

  typedef struct {
    logic [63:0] digest;
    logic        match;
  } sb_t;

  sb_t sbq[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one full digest, checking the running count and the 1-cycle latency
  task automatic send_stream(input logic [63:0] d, input logic [63:0] tag, input logic m);
    bus.exp_tag = tag;
    for (int i = 0; i < 16; i++) begin
      bus.nib_in    = d[63-4*i -: 4];
      bus.nib_valid = 1'b1;
      if (i == 15) sbq.push_back('{digest: d, match: m});
      tick();
      check("nib_count", 64'(bus.nib_count), 64'(i + 1));
      check("valid_latency", 64'(bus.digest_valid), 64'(i == 15));
    end
    bus.nib_valid = 1'b0;
  endtask

  // Scoreboard: a handshake seen at the negedge retires the oldest expected digest
  always @(negedge clk) begin
    if (reset_n && bus.digest_valid && bus.digest_ready) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_digest", 64'(bus.digest_valid), 64'd0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        check("sb_digest", bus.digest_out, e.digest);
        check("sb_tag_match", 64'(bus.tag_match), 64'(e.match));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[4];

  initial begin
    logic [63:0] held;
    vecs[0] = '{data: 64'h123456789ABCDEF1, tag: 64'h123456789ABCDEF1, match: 1'b1};
    vecs[1] = '{data: 64'h123456789ABCDEF1, tag: 64'h6A09E66712345678, match: 1'b0};
    vecs[2] = '{data: 64'h0000000000000000, tag: 64'h0000000000000000, match: 1'b1};
    vecs[3] = '{data: 64'hFFFFFFFFFFFFFFFF, tag: 64'hFFFFFFFFFFFFFFFE, match: 1'b0};

    reset_n          = 1'b0;
    bus.clear        = 1'b0;
    bus.nib_in       = '0;
    bus.nib_valid    = 1'b0;
    bus.exp_tag      = '0;
    bus.digest_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_digest_out", bus.digest_out, 64'd0);
    check("rst_valid", 64'(bus.digest_valid), 64'd0);
    check("rst_tag_match", 64'(bus.tag_match), 64'd0);
    check("rst_count", 64'(bus.nib_count), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Table-driven single digests with ready held high
    for (int v = 0; v < 4; v++) begin
      bus.digest_ready = 1'b1;
      send_stream(vecs[v].data, vecs[v].tag, vecs[v].match);
      check("tbl_digest", bus.digest_out, vecs[v].data);
      check("tbl_tag_match", 64'(bus.tag_match), 64'(vecs[v].match));
      tick();
      check("tbl_idle_valid", 64'(bus.digest_valid), 64'd0);
      check("tbl_idle_count", 64'(bus.nib_count), 64'd0);
    end

    // Held digest while the consumer stalls; two nibbles are lost
    bus.digest_ready = 1'b0;
    held = 64'hBB67AE8523456789;
    send_stream(held, held, 1'b1);
    for (int c = 0; c < 5; c++) begin
      bus.nib_valid = (c == 1 || c == 3);
      bus.nib_in    = 4'hE;
      tick();
      check("hold_valid", 64'(bus.digest_valid), 64'd1);
      check("hold_digest", bus.digest_out, held);
      check("hold_count", 64'(bus.nib_count), 64'd16);
    end
    bus.nib_valid = 1'b0;
    check("hold_overflow", 64'(bus.overflow), 64'd1);
    bus.digest_ready = 1'b1;
    tick();
    check("accept_valid", 64'(bus.digest_valid), 64'd0);
    check("accept_count", 64'(bus.nib_count), 64'd0);
    check("overflow_sticky", 64'(bus.overflow), 64'd1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clear_overflow", 64'(bus.overflow), 64'd0);
    check("clear_tag_match", 64'(bus.tag_match), 64'd0);
    check("clear_keeps_digest", bus.digest_out, held);

    // Back-to-back digests, ready high when B's first nibble lands in HOLD
    send_stream(64'hBB67AE8523456789, 64'hBB67AE8523456789, 1'b1);
    send_stream(64'h6A09E66734567891, 64'h6A09E66734567891, 1'b1);
    tick();
    check("b2b_overflow", 64'(bus.overflow), 64'd0);
    check("b2b_idle", 64'(bus.digest_valid), 64'd0);

    // Clear after 7 nibbles (nibble in the clear cycle is discarded)
    for (int i = 0; i < 7; i++) begin
      bus.nib_in    = 4'(i + 8);
      bus.nib_valid = 1'b1;
      tick();
    end
    check("pre_clear_count", 64'(bus.nib_count), 64'd7);
    bus.clear  = 1'b1;
    bus.nib_in = 4'hF;
    tick();
    bus.clear     = 1'b0;
    bus.nib_valid = 1'b0;
    check("clear_count", 64'(bus.nib_count), 64'd0);
    check("clear_valid", 64'(bus.digest_valid), 64'd0);
    send_stream(64'hC0FFEE0012345678, 64'hC0FFEE0012345678, 1'b1);
    tick();

    // Asynchronous reset in the middle of nibble 9
    for (int i = 0; i < 8; i++) begin
      bus.nib_in    = 4'(i);
      bus.nib_valid = 1'b1;
      tick();
    end
    bus.nib_in = 4'h9;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_digest", bus.digest_out, 64'd0);
    check("async_rst_count", 64'(bus.nib_count), 64'd0);
    check("async_rst_valid", 64'(bus.digest_valid), 64'd0);
    check("async_rst_tag", 64'(bus.tag_match), 64'd0);
    bus.nib_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_rst_count", 64'(bus.nib_count), 64'd0);
    send_stream(64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b1);
    check("post_rst_digest", bus.digest_out, 64'h0123456789ABCDEF);
    tick();

    check("sb_drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
